// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and memory-side signal bundle for mem_arbiter
// slave: arbiter view; master: requesters plus memory instance view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              done0;
    logic              done1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mem_data_out;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_data_out,
        output gnt0, gnt1, done0, done1, rdata0, rdata1,
               mem_read, mem_write, mem_addr, mem_data_in
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_data_out,
        input  gnt0, gnt1, done0, done1, rdata0, rdata1,
               mem_read, mem_write, mem_addr, mem_data_in
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port arbiter/sequencer for a 32x8 single-port memory
// MEM_ARB_RR_EN selects round-robin tie-breaking; otherwise requester 0 has fixed priority.
module mem_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    mem_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RCAP, S_DONE} state_t;

    state_t            r_state, w_state_nxt;
    logic              r_win, w_win_nxt;
    logic              r_we, w_we_nxt;
    logic              r_gnt0, r_gnt1, w_gnt0_nxt, w_gnt1_nxt;
    logic              r_done0, r_done1, w_done0_nxt, w_done1_nxt;
    logic [DATA_W-1:0] r_rdata0, r_rdata1, w_rdata0_nxt, w_rdata1_nxt;
    logic              r_mem_read, r_mem_write, w_mem_read_nxt, w_mem_write_nxt;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [DATA_W-1:0] r_mem_data_in, w_mem_data_in_nxt;

    logic              w_any_req;
    logic              w_pick;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

    assign w_any_req = bus.req0 | bus.req1;

`ifdef MEM_ARB_RR_EN
    logic r_ptr;

    assign w_pick = (bus.req0 && bus.req1) ? r_ptr : bus.req1;

    // Pointer always names the port that lost the most recent grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (r_state == S_IDLE && w_any_req) begin
            r_ptr <= ~w_pick;
        end
    end
`else
    assign w_pick = ~bus.req0;
`endif

    always_comb begin
        w_sel_we    = w_pick ? bus.we1    : bus.we0;
        w_sel_addr  = w_pick ? bus.addr1  : bus.addr0;
        w_sel_wdata = w_pick ? bus.wdata1 : bus.wdata0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_win         <= 1'b0;
            r_we          <= 1'b0;
            r_gnt0        <= 1'b0;
            r_gnt1        <= 1'b0;
            r_done0       <= 1'b0;
            r_done1       <= 1'b0;
            r_rdata0      <= '0;
            r_rdata1      <= '0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_data_in <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_win         <= w_win_nxt;
            r_we          <= w_we_nxt;
            r_gnt0        <= w_gnt0_nxt;
            r_gnt1        <= w_gnt1_nxt;
            r_done0       <= w_done0_nxt;
            r_done1       <= w_done1_nxt;
            r_rdata0      <= w_rdata0_nxt;
            r_rdata1      <= w_rdata1_nxt;
            r_mem_read    <= w_mem_read_nxt;
            r_mem_write   <= w_mem_write_nxt;
            r_mem_addr    <= w_mem_addr_nxt;
            r_mem_data_in <= w_mem_data_in_nxt;
        end
    end

    // Next values of every registered output are computed here so all outputs stay flop-driven.
    always_comb begin
        w_state_nxt       = r_state;
        w_win_nxt         = r_win;
        w_we_nxt          = r_we;
        w_gnt0_nxt        = r_gnt0;
        w_gnt1_nxt        = r_gnt1;
        w_done0_nxt       = 1'b0;
        w_done1_nxt       = 1'b0;
        w_rdata0_nxt      = r_rdata0;
        w_rdata1_nxt      = r_rdata1;
        w_mem_read_nxt    = 1'b0;
        w_mem_write_nxt   = 1'b0;
        w_mem_addr_nxt    = r_mem_addr;
        w_mem_data_in_nxt = r_mem_data_in;

        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_win_nxt      = w_pick;
                    w_we_nxt       = w_sel_we;
                    w_gnt0_nxt     = ~w_pick;
                    w_gnt1_nxt     = w_pick;
                    w_mem_addr_nxt = w_sel_addr;
                    if (w_sel_we) begin
                        w_mem_write_nxt   = 1'b1;
                        w_mem_data_in_nxt = w_sel_wdata;
                    end else begin
                        w_mem_read_nxt = 1'b1;
                    end
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (r_we) begin
                    w_done0_nxt = ~r_win;
                    w_done1_nxt = r_win;
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_RCAP;
                end
            end
            S_RCAP: begin
                if (r_win) begin
                    w_rdata1_nxt = bus.mem_data_out;
                end else begin
                    w_rdata0_nxt = bus.mem_data_out;
                end
                w_done0_nxt = ~r_win;
                w_done1_nxt = r_win;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_gnt0_nxt  = 1'b0;
                w_gnt1_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.gnt0        = r_gnt0;
    assign bus.gnt1        = r_gnt1;
    assign bus.done0       = r_done0;
    assign bus.done1       = r_done1;
    assign bus.rdata0      = r_rdata0;
    assign bus.rdata1      = r_rdata1;
    assign bus.mem_read    = r_mem_read;
    assign bus.mem_write   = r_mem_write;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_data_in = r_mem_data_in;
endmodule
